// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode codes and FSM states for the universal shift register
// Purpose: MODE encodings, FSM state type and a mode classification helper.
// Ports: none (package).
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Hold, load and the reserved code always run exactly one step and ignore N.
  function automatic logic mode_is_single(input logic [2:0] mode);
    return (mode == MODE_HOLD) || (mode == MODE_LOAD) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - combinational single-step next value of the shift register
// Purpose: computes the register value after one step of the given mode.
// Ports:
//   cur_i  [WIDTH-1:0]  current register contents
//   mode_i [2:0]        operation code
//   dsr_i               serial input entering at the MSB on shift right
//   dsl_i               serial input entering at the LSB on shift left
//   d_i    [WIDTH-1:0]  parallel load data
//   nxt_o  [WIDTH-1:0]  value after one step
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [2:0]       mode_i,
  input  logic             dsr_i,
  input  logic             dsl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (mode_i)
      MODE_SHR:  nxt_o = {dsr_i, cur_i[WIDTH-1:1]};
      MODE_SHL:  nxt_o = {cur_i[WIDTH-2:0], dsl_i};
      MODE_LOAD: nxt_o = d_i;
      MODE_ROR:  nxt_o = {cur_i[0], cur_i[WIDTH-1:1]};
      MODE_ROL:  nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
      // Repeating this step saturates to all sign bits for any N >= WIDTH-1.
      MODE_ASR:  nxt_o = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
      default:   nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - multi-step universal shift register with START/BUSY/DONE handshake
// Purpose: FSM, step counter and registered Q/Qn/BUSY/DONE around the usr_step function.
// Ports:
//   CLK                 rising-edge clock
//   R                   synchronous active-high reset
//   START               operation request, sampled only in IDLE
//   MODE  [2:0]         operation, latched on accept
//   N     [CNT_W-1:0]   step count, latched on accept
//   D     [WIDTH-1:0]   parallel load data, sampled live at the load edge
//   DSR, DSL            serial inputs, sampled live at each step edge
//   Q, Qn [WIDTH-1:0]   register contents and registered complement
//   BUSY                operation in progress
//   DONE                one-cycle completion pulse
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [CNT_W-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic             DSR,
  input  logic             DSL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             BUSY,
  output logic             DONE
);

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   qn_q, qn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_nxt;

  usr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur_i  (q_q),
    .mode_i (mode_q),
    .dsr_i  (DSR),
    .dsl_i  (DSL),
    .d_i    (D),
    .nxt_o  (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d = MODE;
          if (mode_is_single(MODE)) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else if (N == '0) begin
            // Zero-step shift: acknowledge immediately without entering RUN.
            done_d = 1'b1;
          end else begin
            cnt_d   = N;
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        q_d   = step_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Complement is registered with Q so both ports change on the same edge.
    qn_d = ~q_d;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      qn_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Qn   = qn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg at widths 8, 2 and 16
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        start8 = 1'b0, start2 = 1'b0, start16 = 1'b0;
  logic [2:0]  s_mode = 3'b000;
  logic [4:0]  s_n = 5'd0;
  logic [15:0] s_d = 16'h0;
  logic        s_dsr = 1'b0, s_dsl = 1'b0;

  logic [7:0]  q8, qn8;
  logic [1:0]  q2, qn2;
  logic [15:0] q16, qn16;
  logic        busy8, done8, busy2, done2, busy16, done16;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] mq2 = 16'h0, mq16 = 16'h0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .CLK(clk), .R(r), .START(start8), .MODE(s_mode), .N(s_n[3:0]), .D(s_d[7:0]),
    .DSR(s_dsr), .DSL(s_dsl), .Q(q8), .Qn(qn8), .BUSY(busy8), .DONE(done8)
  );

  univ_shift_reg #(.WIDTH(2)) dut2 (
    .CLK(clk), .R(r), .START(start2), .MODE(s_mode), .N(s_n[1:0]), .D(s_d[1:0]),
    .DSR(s_dsr), .DSL(s_dsl), .Q(q2), .Qn(qn2), .BUSY(busy2), .DONE(done2)
  );

  univ_shift_reg #(.WIDTH(16)) dut16 (
    .CLK(clk), .R(r), .START(start16), .MODE(s_mode), .N(s_n), .D(s_d),
    .DSR(s_dsr), .DSL(s_dsl), .Q(q16), .Qn(qn16), .BUSY(busy16), .DONE(done16)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("%s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one step for a register of width w (w <= 16).
  function automatic logic [15:0] ref_step(input logic [15:0] cur, input int w,
                                           input logic [2:0] m, input logic dsr,
                                           input logic dsl, input logic [15:0] d);
    logic [31:0] r32;
    logic [31:0] msk;
    msk = (32'd1 << w) - 32'd1;
    r32 = {16'h0, cur};
    case (m)
      M_SHR:  begin r32 = r32 >> 1; r32[w-1] = dsr; end
      M_SHL:  r32 = (r32 << 1) | {31'd0, dsl};
      M_LOAD: r32 = {16'h0, d};
      M_ROR:  begin r32 = r32 >> 1; r32[w-1] = cur[0]; end
      M_ROL:  r32 = (r32 << 1) | {31'd0, cur[w-1]};
      M_ASR:  begin r32 = r32 >> 1; r32[w-1] = cur[w-1]; end
      default: r32 = {16'h0, cur};
    endcase
    return r32[15:0] & msk[15:0];
  endfunction

  // One operation on the 8-bit DUT; optional START poke while busy at cycle 'poke'.
  task automatic run_op8(input string tag, input logic [2:0] m, input logic [4:0] n,
                         input logic [15:0] d, input logic dsr, input logic dsl,
                         input logic [7:0] exp_q, input int exp_busy, input int poke);
    int  busy_cnt;
    bit  seen;
    logic [15:0] e;
    sb.push_back({8'h00, exp_q});
    start8 = 1'b1; s_mode = m; s_n = n; s_d = d; s_dsr = dsr; s_dsl = dsl;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (poke != 0 && cyc == poke) begin
        start8 = 1'b1; s_mode = M_LOAD; s_d = 16'h0000;
      end else if (poke != 0 && cyc == poke + 1) begin
        start8 = 1'b0; s_mode = m; s_d = d;
      end
      if (done8) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk({tag, "_q"}, 16'(q8), e);
        chk({tag, "_qn"}, 16'(qn8), ~e & 16'h00FF);
        chk({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_busy));
        chk({tag, "_latency"}, 16'(cyc), 16'(exp_busy + 1));
        chk({tag, "_busy_at_done"}, 16'(busy8), 16'h0);
      end else begin
        if (busy8) busy_cnt++;
        @(negedge clk);
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 16'h0, 16'h1);
  endtask

  // Random operation on the width-w DUT, checked step by step against the model.
  task automatic sweep_op(input int w);
    logic [2:0]  m;
    int          n, steps;
    logic [15:0] mq, e, qv, qnv, msk;
    logic        bz, dn;
    msk = (w == 16) ? 16'hFFFF : 16'h0003;
    mq  = (w == 16) ? mq16 : mq2;
    m   = 3'($urandom_range(0, 7));
    n   = (w == 16) ? $urandom_range(0, 31) : $urandom_range(0, 3);
    steps = (m == M_HOLD || m == M_LOAD || m == M_RSVD) ? 1 : n;
    s_mode = m; s_n = 5'(n);
    if (w == 16) start16 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < steps; i++) begin
      bz = (w == 16) ? busy16 : busy2;
      chk($sformatf("w%0d_busy_step", w), 16'(bz), 16'h1);
      s_dsr = 1'($urandom); s_dsl = 1'($urandom); s_d = 16'($urandom);
      sb.push_back(ref_step(mq, w, m, s_dsr, s_dsl, s_d));
      @(negedge clk);
      e   = sb.pop_front();
      qv  = (w == 16) ? q16 : {14'h0, q2};
      qnv = (w == 16) ? qn16 : {14'h0, qn2};
      chk($sformatf("w%0d_q_mode%0d", w, m), qv, e);
      chk($sformatf("w%0d_qn", w), qnv, ~qv & msk);
      mq = e;
    end
    dn  = (w == 16) ? done16 : done2;
    bz  = (w == 16) ? busy16 : busy2;
    qv  = (w == 16) ? q16 : {14'h0, q2};
    chk($sformatf("w%0d_done", w), 16'(dn), 16'h1);
    chk($sformatf("w%0d_idle_busy", w), 16'(bz), 16'h0);
    chk($sformatf("w%0d_q_end", w), qv, mq);
    if (w == 16) mq16 = mq; else mq2 = mq;
  endtask

  initial begin
    int dcount;
    repeat (3) @(negedge clk);
    r = 1'b0;

    // Random activity, then a 2-cycle reset in the middle of a run.
    start8 = 1'b1; s_mode = M_LOAD; s_d = 16'($urandom);
    @(negedge clk);
    start8 = 1'b1; s_mode = M_SHL; s_n = 5'd7; s_dsl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    r = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q", 16'(q8), 16'h0000);
    chk("rst_qn", 16'(qn8), 16'h00FF);
    chk("rst_busy", 16'(busy8), 16'h0);
    chk("rst_done", 16'(done8), 16'h0);
    r = 1'b0;
    dcount = 0;
    repeat (10) begin @(negedge clk); if (done8) dcount++; end
    chk("rst_no_done", 16'(dcount), 16'h0);
    chk("rst_q_hold", 16'(q8), 16'h0000);

    run_op8("load_a5", M_LOAD, 5'd0, 16'h00A5, 1'b0, 1'b0, 8'hA5, 1, 0);
    @(negedge clk);
    chk("done_one_cycle", 16'(done8), 16'h0);
    run_op8("shr3",    M_SHR,  5'd3, 16'h0000, 1'b1, 1'b0, 8'hF4, 3, 0);
    run_op8("load_81", M_LOAD, 5'd0, 16'h0081, 1'b0, 1'b0, 8'h81, 1, 0);
    run_op8("rol9",    M_ROL,  5'd9, 16'h0000, 1'b0, 1'b0, 8'h03, 9, 0);
    run_op8("load_80", M_LOAD, 5'd0, 16'h0080, 1'b0, 1'b0, 8'h80, 1, 0);
    run_op8("asr10",   M_ASR,  5'd10, 16'h0000, 1'b0, 1'b0, 8'hFF, 10, 0);
    run_op8("hold",    M_HOLD, 5'd5, 16'h0012, 1'b0, 1'b0, 8'hFF, 1, 0);
    run_op8("rsvd",    M_RSVD, 5'd3, 16'h0034, 1'b0, 1'b0, 8'hFF, 1, 0);
    run_op8("shr_n0",  M_SHR,  5'd0, 16'h0000, 1'b0, 1'b0, 8'hFF, 0, 0);
    @(negedge clk);
    chk("n0_done_one_cycle", 16'(done8), 16'h0);
    chk("n0_q_unchanged", 16'(q8), 16'h00FF);

    // START during BUSY must be ignored and not queued.
    run_op8("shl4_poke", M_SHL, 5'd4, 16'h0000, 1'b0, 1'b0, 8'hF0, 4, 2);
    @(negedge clk);
    chk("poke_not_queued_busy", 16'(busy8), 16'h0);
    chk("poke_not_queued_q", 16'(q8), 16'h00F0);

    // Second START raised during the DONE cycle of the first.
    run_op8("ror1", M_ROR, 5'd1, 16'h0000, 1'b0, 1'b0, 8'h78, 1, 0);
    run_op8("ror2_b2b", M_ROR, 5'd2, 16'h0000, 1'b0, 1'b0, 8'h1E, 2, 0);

    // Single-cycle reset aborting a run.
    start8 = 1'b1; s_mode = M_SHL; s_n = 5'd8; s_dsl = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 16'(busy8), 16'h1);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    chk("abort_q", 16'(q8), 16'h0000);
    chk("abort_qn", 16'(qn8), 16'h00FF);
    chk("abort_busy", 16'(busy8), 16'h0);
    dcount = 0;
    repeat (12) begin @(negedge clk); if (done8) dcount++; end
    chk("abort_no_done", 16'(dcount), 16'h0);

    mq2 = 16'h0;
    mq16 = 16'h0;
    repeat (25) sweep_op(2);
    repeat (25) sweep_op(16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
